// File: rtl/reverb_tap_scheduler.sv
// Per-sample sequencer for the shared sample/impulse memory of the convolution reverb.
// Writes the new sample to the delay ring, then walks the tap table and accumulates a saturated wet+dry output.
module reverb_tap_scheduler #(
    parameter int          MAX_TAPS = 255,
    parameter logic [15:0] BUF_BASE = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_stb,
    input  logic [15:0] sample_in,
    input  logic        record,
    input  logic [8:0]  num_taps,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] out_sample,
    output logic        out_valid,
    output logic        busy,
    output logic        overrun
);

    localparam logic [16:0] BUF_LEN = 17'h10000 - {1'b0, BUF_BASE};
    localparam logic [8:0]  MAX_T   = 9'(MAX_TAPS);

    typedef enum logic [2:0] {IDLE, WRITE, TAP_RD, SMP_RD, MAC, DONE} state_t;

    state_t             state;
    logic [15:0]        wr_ptr;
    logic [15:0]        cum_d;
    logic [8:0]         tap_idx;
    logic [8:0]         count;
    logic               rec;
    logic               tap_neg;
    logic [7:0]         tap_gain;
    logic [15:0]        smp;
    logic signed [31:0] acc;

    logic [8:0]         taps_clamped;
    logic [8:0]         idx_next;
    logic [16:0]        d_sum;
    logic [15:0]        d_next;
    logic [16:0]        diff;
    logic [16:0]        diff_wrap;
    logic [15:0]        smp_addr;
    logic signed [24:0] prod;
    logic signed [31:0] prod_ext;
    logic signed [31:0] acc_sh;
    logic [15:0]        sat;

    assign taps_clamped = (num_taps > MAX_T) ? MAX_T : num_taps;
    assign idx_next     = tap_idx + 9'd1;

    // Cumulative delay saturates one short of the ring length so the read never aliases.
    assign d_sum     = {1'b0, cum_d} + {10'b0, mem_rdata[15:9]};
    assign d_next    = (d_sum >= BUF_LEN) ? 16'(BUF_LEN - 17'd1) : d_sum[15:0];
    assign diff      = {1'b0, wr_ptr} - {1'b0, d_next};
    assign diff_wrap = diff + BUF_LEN;
    assign smp_addr  = (diff[16] || (diff[15:0] < BUF_BASE)) ? diff_wrap[15:0] : diff[15:0];

    assign prod     = $signed(smp) * $signed({1'b0, tap_gain});
    assign prod_ext = {{7{prod[24]}}, prod};
    assign acc_sh   = acc >>> 8;
    assign sat      = (acc_sh > 32'sd32767)  ? 16'h7FFF :
                      (acc_sh < -32'sd32768) ? 16'h8000 : acc_sh[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= BUF_BASE;
            cum_d      <= '0;
            tap_idx    <= '0;
            count      <= '0;
            rec        <= 1'b0;
            tap_neg    <= 1'b0;
            tap_gain   <= '0;
            smp        <= '0;
            acc        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (sample_stb && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (sample_stb) begin
                    count   <= taps_clamped;
                    rec     <= record;
                    acc     <= {{8{sample_in[15]}}, sample_in, 8'h00};
                    tap_idx <= '0;
                    cum_d   <= '0;
                    busy    <= 1'b1;
                    if (record) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        mem_wdata <= sample_in;
                    end else begin
                        state    <= TAP_RD;
                        mem_req  <= (taps_clamped != 9'd0);
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                    end
                end
                WRITE: if (mem_ack) begin
                    state    <= TAP_RD;
                    mem_we   <= 1'b0;
                    mem_req  <= (count != 9'd0);
                    mem_addr <= '0;
                end
                TAP_RD: begin
                    if (tap_idx == count) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                    end else if (mem_ack) begin
                        tap_neg  <= mem_rdata[8];
                        tap_gain <= mem_rdata[7:0];
                        cum_d    <= d_next;
                        mem_addr <= smp_addr;
                        state    <= SMP_RD;
                    end
                end
                SMP_RD: if (mem_ack) begin
                    smp     <= mem_rdata;
                    mem_req <= 1'b0;
                    state   <= MAC;
                end
                MAC: begin
                    acc      <= tap_neg ? (acc - prod_ext) : (acc + prod_ext);
                    tap_idx  <= idx_next;
                    mem_req  <= (idx_next != count);
                    mem_addr <= {7'b0, idx_next};
                    state    <= TAP_RD;
                end
                DONE: begin
                    out_sample <= sat;
                    out_valid  <= 1'b1;
                    if (rec)
                        wr_ptr <= (wr_ptr == 16'hFFFF) ? BUF_BASE : (wr_ptr + 16'd1);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reverb_tap_scheduler.sv
// Directed bench for reverb_tap_scheduler with a behavioural SRAM that acks after a programmable delay.
module tb_reverb_tap_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_stb;
    logic [15:0] sample_in;
    logic        record;
    logic [8:0]  num_taps;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    reverb_tap_scheduler dut (
        .clk(clk), .rst(rst), .sample_stb(sample_stb), .sample_in(sample_in),
        .record(record), .num_taps(num_taps), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_sample(out_sample), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    logic [15:0] rd_log [0:7];
    logic [15:0] held_addr;
    logic [15:0] last_wr_addr;
    logic [15:0] last_wr_data;
    int ack_delay = 1;
    int cnt = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int vld_cnt = 0;
    int stab_err = 0;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: acks ack_delay cycles after the request first appears.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (rst) begin
            cnt = 0;
        end else if (mem_req) begin
            if (cnt == 0) held_addr = mem_addr;
            else if (mem_addr !== held_addr) stab_err++;
            if (cnt == ack_delay) begin
                mem_ack = 1'b1;
                cnt = 0;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_cnt++;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr];
                    if (rd_cnt < 8) rd_log[rd_cnt] = mem_addr;
                    rd_cnt++;
                end
            end else begin
                cnt++;
            end
        end
        if (out_valid) vld_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_sample(input logic [15:0] s, input logic [8:0] n, input logic rec,
                              output logic [15:0] res, output int lat);
        int t0;
        logic got;
        @(negedge clk);
        wr_cnt = 0; rd_cnt = 0; vld_cnt = 0;
        sample_stb = 1'b1; sample_in = s; num_taps = n; record = rec;
        t0 = cyc;
        @(negedge clk);
        sample_stb = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            if (out_valid) got = 1'b1;
            else @(negedge clk);
        end
        lat = cyc - t0;
        res = out_sample;
        chk("out_valid_seen", {31'b0, got}, 32'd1);
        @(negedge clk);
        chk("out_valid_pulse", {31'b0, out_valid}, 32'd0);
    endtask

    logic [15:0] res;
    int lat;
    logic found;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        rst = 1'b1; sample_stb = 1'b0; sample_in = '0; record = 1'b1; num_taps = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_sample", {16'b0, out_sample}, 32'h0);
        rst = 1'b0;

        // Dry path only: single write, output equals input
        run_sample(16'h1000, 9'd0, 1'b1, res, lat);
        chk("t1_wr_cnt", wr_cnt, 32'd1);
        chk("t1_wr_addr", {16'b0, last_wr_addr}, 32'h0100);
        chk("t1_wr_data", {16'b0, last_wr_data}, 32'h1000);
        chk("t1_rd_cnt", rd_cnt, 32'd0);
        chk("t1_out", {16'b0, res}, 32'h1000);
        chk("t1_latency", lat, 32'd5);

        // One tap, delay 1, gain 0.5
        mem[0] = 16'h0280;
        run_sample(16'h2000, 9'd1, 1'b1, res, lat);
        chk("t2a_wr_addr", {16'b0, last_wr_addr}, 32'h0101);
        chk("t2a_out", {16'b0, res}, 32'h2800);
        chk("t2a_latency", lat, 32'd10);
        run_sample(16'h0000, 9'd1, 1'b1, res, lat);
        chk("t2b_out", {16'b0, res}, 32'h1000);
        chk("t2b_rd_cnt", rd_cnt, 32'd2);
        chk("t2b_rd0", {16'b0, rd_log[0]}, 32'h0000);
        chk("t2b_rd1", {16'b0, rd_log[1]}, 32'h0101);
        chk("t2b_wr_addr", {16'b0, last_wr_addr}, 32'h0102);

        // Negated tap at delay 0 reads the sample just written
        mem[0] = 16'h01FF;
        run_sample(16'h4000, 9'd1, 1'b1, res, lat);
        chk("t3_out", {16'b0, res}, 32'h0040);
        chk("t3_wr_addr", {16'b0, last_wr_addr}, 32'h0103);

        // Frozen buffer: no writes, same window re-read
        mem[0] = 16'h0280;
        run_sample(16'h0001, 9'd1, 1'b0, res, lat);
        chk("t4a_out", {16'b0, res}, 32'h2001);
        chk("t4a_wr_cnt", wr_cnt, 32'd0);
        run_sample(16'h0002, 9'd1, 1'b0, res, lat);
        chk("t4b_out", {16'b0, res}, 32'h2002);
        chk("t4b_rd1", {16'b0, rd_log[1]}, 32'h0103);
        chk("t4b_wr_cnt", wr_cnt, 32'd0);

        // Write pointer wrap at the top of memory
        @(negedge clk);
        force dut.wr_ptr = 16'hFFFF;
        @(negedge clk);
        release dut.wr_ptr;
        run_sample(16'h1234, 9'd0, 1'b1, res, lat);
        chk("t5a_wr_addr", {16'b0, last_wr_addr}, 32'hFFFF);
        chk("t5a_out", {16'b0, res}, 32'h1234);
        mem[0] = 16'h0480;
        mem[16'hFFFE] = 16'h0600;
        run_sample(16'h0000, 9'd1, 1'b1, res, lat);
        chk("t5b_wr_addr", {16'b0, last_wr_addr}, 32'h0100);
        chk("t5b_rd1", {16'b0, rd_log[1]}, 32'hFFFE);
        chk("t5b_out", {16'b0, res}, 32'h0300);

        // Saturation, both rails
        mem[0] = 16'h00FF;
        mem[1] = 16'h00FF;
        run_sample(16'h7FFF, 9'd2, 1'b1, res, lat);
        chk("t6a_out", {16'b0, res}, 32'h7FFF);
        chk("t6a_latency", lat, 32'd15);
        run_sample(16'h8000, 9'd2, 1'b1, res, lat);
        chk("t6b_out", {16'b0, res}, 32'h8000);
        chk("t6_overrun_clear", {31'b0, overrun}, 32'd0);

        // Slow memory plus a strobe while busy
        ack_delay = 5;
        mem[0] = 16'h0080;
        @(negedge clk);
        wr_cnt = 0; rd_cnt = 0; vld_cnt = 0; stab_err = 0;
        sample_stb = 1'b1; sample_in = 16'h0200; num_taps = 9'd1; record = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        repeat (3) @(negedge clk);
        sample_stb = 1'b1; sample_in = 16'h7777;
        @(negedge clk);
        sample_stb = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else @(negedge clk);
        end
        res = out_sample;
        repeat (20) @(negedge clk);
        chk("t7_valid_seen", {31'b0, found}, 32'd1);
        chk("t7_out", {16'b0, res}, 32'h0300);
        chk("t7_overrun", {31'b0, overrun}, 32'd1);
        chk("t7_vld_cnt", vld_cnt, 32'd1);
        chk("t7_addr_stable", stab_err, 32'd0);
        chk("t7_wr_cnt", wr_cnt, 32'd1);

        // Reset during the sample read
        @(negedge clk);
        sample_stb = 1'b1; sample_in = 16'h0100; num_taps = 9'd1; record = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (mem_req && !mem_we && mem_addr >= 16'h0100) found = 1'b1;
            else @(negedge clk);
        end
        chk("t8_smp_rd_seen", {31'b0, found}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t8_rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("t8_rst_busy", {31'b0, busy}, 32'd0);
        chk("t8_rst_overrun", {31'b0, overrun}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vld_cnt = 0;
        repeat (20) @(negedge clk);
        chk("t8_no_output", vld_cnt, 32'd0);
        ack_delay = 1;
        run_sample(16'h0005, 9'd0, 1'b1, res, lat);
        chk("t8_wr_addr", {16'b0, last_wr_addr}, 32'h0100);
        chk("t8_out", {16'b0, res}, 32'h0005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reverb_tap_scheduler.md
Name: reverb_tap_scheduler

Overview:
- Sequences the shared 16-bit sample/impulse memory for the convolution reverb path, once per ADC sample.
- On each sample strobe it:
  - writes the new sample into a circular delay buffer;
  - walks the impulse tap table, reading each tap word and then its delayed sample;
  - multiply-accumulates the taps and presents one saturated 16-bit result with a valid pulse.
- Sits between the ADC sample register and the SRAM/off-chip memory port; it is the only master of that port.

Parameters:
- MAX_TAPS, 255, upper bound on num_taps; larger values clamp to this.
- BUF_BASE, 16'h0100, first delay-buffer address. Tap table occupies 0..BUF_BASE-1; buffer occupies BUF_BASE..16'hFFFF.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- sample_stb  in  1  single-cycle pulse, new ADC sample available (clk-synchronous)
- sample_in  in  16  signed ADC sample, valid while sample_stb is high
- record  in  1  1 = write samples to buffer; 0 = buffer frozen (loop playback)
- num_taps  in  9  taps to process this sample; sampled at sample_stb
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  16  memory address
- mem_wdata  out  16  write data
- mem_ack  in  1  one-cycle completion; mem_rdata valid in the same cycle
- mem_rdata  in  16  read data
- out_sample  out  16  signed wet+dry result
- out_valid  out  1  one-cycle pulse when out_sample updates
- busy  out  1  high from accepted strobe until DONE
- overrun  out  1  sticky; a strobe arrived while busy

Behaviour:
- Reset (async, rst=1) forces all outputs to 0. Internal state on reset:
  - state IDLE;
  - wr_ptr = BUF_BASE;
  - accumulator, tap index and cumulative delay = 0.
- Tap word format:
  - [15:9] delay increment d (unsigned, relative to the previous tap);
  - [8] negate;
  - [7:0] gain g (unsigned Q0.8).
  - Cumulative delay D_k = sum of d over taps 0..k, held in 16 bits.
- States:
  - IDLE: on sample_stb, latch sample_in and min(num_taps, MAX_TAPS). Set acc = sign-extended sample_in << 8 (unity dry path), set busy, go to WRITE if record=1, else TAP_RD.
  - WRITE: mem_req=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=sample. On mem_ack, go to TAP_RD.
  - TAP_RD: if tap index == latched count, go to DONE. Otherwise read address = tap index. On ack, latch the tap word and add d to D; go to SMP_RD.
  - SMP_RD: read address = wr_ptr - D, wrapped into the buffer (if the result is < BUF_BASE or underflows, add 65536-BUF_BASE). On ack go to MAC.
  - MAC (1 cycle): p = rdata * g (24-bit signed); acc = acc - p if negate, else acc + p. Increment tap index, go to TAP_RD.
  - DONE (1 cycle): out_sample = saturate(acc >>> 8) to [-32768, 32767], out_valid=1. If record=1, advance wr_ptr (16'hFFFF wraps to BUF_BASE). Clear busy, go to IDLE.
- Accumulator is 32-bit signed; no wrap is possible at MAX_TAPS=255.
- If D reaches or exceeds the buffer length (65536-BUF_BASE), clamp D to length-1.
- mem_req is held with a stable address, we and wdata until mem_ack. Only one outstanding access; no bus cycle in IDLE, MAC or DONE.
- The sample just written is at delay 0: a tap with D=0 reads the current sample.
- With num_taps=0: WRITE (if record), then DONE. Output equals the dry sample.
- Strobe while busy: dropped, overrun set; cleared only by rst.
- Strobe in the same cycle as DONE: dropped, overrun set. The strobe is accepted only in IDLE.
- rst asserted mid-transaction: mem_req drops immediately; any partial result is discarded.
- record=0: wr_ptr is frozen, so repeated strobes re-read the same window (loop).
- Latency with mem_ack returned 1 cycle after request, N taps: from strobe to out_valid = 1 + 2 (write) + N*(2+2+1) + 1 (final TAP_RD) + 1 cycles.

Test Plan:
- rst, then strobe sample_in=16'h1000, record=1, num_taps=0 -> one write at addr 16'h0100 with data 16'h1000. out_sample=16'h1000, out_valid 1 cycle; wr_ptr becomes 16'h0101.
- Preload tap0 = {d=1, neg=0, g=8'h80}. Strobe 16'h2000 then 16'h0000 with num_taps=1 -> second output 16'h1000 (half of the previous sample). Reads occur at addresses 16'h0000 and 16'h0101.
- Tap {d=0, neg=1, g=8'hFF}, strobe 16'h4000 -> out = 16'h4000 - 16'h3FC0 = 16'h0040.
- Force wr_ptr=16'hFFFF, record=1, strobe -> write at 16'hFFFF, next write at 16'h0100. A tap with D=2 from wr_ptr 16'h0100 reads 16'hFFFE.
- Two taps with g=8'hFF, d=0, strobe 16'h7FFF -> out_sample saturates at 16'h7FFF. Same with 16'h8000 -> 16'h8000.
- mem_ack delayed 5 cycles, strobe pulsed while busy -> address held stable, overrun=1, exactly one out_valid. Assert rst mid-SMP_RD -> mem_req=0 and busy=0 in the same cycle.
